// File: rtl/str_pack_24to32.sv
// Packs a stream of 24-bit samples into a little-endian 32-bit word stream.
// Frames end word-aligned; a short tail word carries tkeep for its valid bytes.
module str_pack_24to32 #(
    parameter int DW = 24,
    parameter int OW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_axis_tdata,
    input  logic          s_axis_tvalid,
    input  logic          s_axis_tlast,
    output logic          s_axis_tready,
    output logic [OW-1:0] m_axis_tdata,
    output logic [3:0]    m_axis_tkeep,
    output logic          m_axis_tlast,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready
);

    generate
        if (DW != 24 || OW != 32) begin : g_bad_param
            $error("str_pack_24to32: only DW=24 and OW=32 are supported");
        end
    endgenerate

    // Byte-lane mask for a tail word holding cnt bytes.
    function automatic logic [3:0] tail_keep(input logic [1:0] cnt);
        logic [3:0] k;
        case (cnt)
            2'd1:    k = 4'b0001;
            2'd2:    k = 4'b0011;
            2'd3:    k = 4'b0111;
            default: k = 4'b0000;
        endcase
        return k;
    endfunction

    logic          run_r;
    logic          flush_pending_r;
    logic [1:0]    r_r;
    logic [DW-1:0] res_r;
    logic [OW-1:0] tdata_r;
    logic [3:0]    tkeep_r;
    logic          tlast_r;
    logic          tvalid_r;

    logic          out_free_s;
    logic          accept_s;
    logic          emit_s;
    logic [OW-1:0] word_s;
    logic [3:0]    keep_s;
    logic          last_s;
    logic [1:0]    r_nx_s;
    logic [DW-1:0] res_nx_s;
    logic          flush_nx_s;

    assign out_free_s    = !tvalid_r || m_axis_tready;
    assign s_axis_tready = run_r && !flush_pending_r && out_free_s;
    assign accept_s      = s_axis_tvalid && s_axis_tready;

    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tlast  = tlast_r;
    assign m_axis_tvalid = tvalid_r;

    // Next residual state and the word (if any) produced this cycle.
    always_comb begin
        emit_s     = 1'b0;
        word_s     = 32'h0000_0000;
        keep_s     = 4'b0000;
        last_s     = 1'b0;
        r_nx_s     = r_r;
        res_nx_s   = res_r;
        flush_nx_s = flush_pending_r;
        if (flush_pending_r) begin
            // The residual register already holds the zero-padded tail bytes.
            if (out_free_s) begin
                emit_s     = 1'b1;
                word_s     = {8'h00, res_r};
                keep_s     = tail_keep(r_r);
                last_s     = 1'b1;
                r_nx_s     = 2'd0;
                res_nx_s   = 24'h00_0000;
                flush_nx_s = 1'b0;
            end else begin
                flush_nx_s = 1'b1;
            end
        end else if (accept_s) begin
            case (r_r)
                2'd0: begin
                    if (s_axis_tlast) begin
                        emit_s   = 1'b1;
                        word_s   = {8'h00, s_axis_tdata};
                        keep_s   = 4'b0111;
                        last_s   = 1'b1;
                        r_nx_s   = 2'd0;
                        res_nx_s = 24'h00_0000;
                    end else begin
                        r_nx_s   = 2'd3;
                        res_nx_s = s_axis_tdata;
                    end
                end
                2'd3: begin
                    emit_s     = 1'b1;
                    word_s     = {s_axis_tdata[7:0], res_r};
                    keep_s     = 4'b1111;
                    r_nx_s     = 2'd2;
                    res_nx_s   = {8'h00, s_axis_tdata[23:8]};
                    flush_nx_s = s_axis_tlast;
                end
                2'd2: begin
                    emit_s     = 1'b1;
                    word_s     = {s_axis_tdata[15:0], res_r[15:0]};
                    keep_s     = 4'b1111;
                    r_nx_s     = 2'd1;
                    res_nx_s   = {16'h0000, s_axis_tdata[23:16]};
                    flush_nx_s = s_axis_tlast;
                end
                2'd1: begin
                    emit_s   = 1'b1;
                    word_s   = {s_axis_tdata, res_r[7:0]};
                    keep_s   = 4'b1111;
                    last_s   = s_axis_tlast;
                    r_nx_s   = 2'd0;
                    res_nx_s = 24'h00_0000;
                end
                default: begin
                    r_nx_s   = 2'd0;
                    res_nx_s = 24'h00_0000;
                end
            endcase
        end else begin
            emit_s = 1'b0;
        end
    end

    // Packing state and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r           <= 1'b0;
            flush_pending_r <= 1'b0;
            r_r             <= 2'd0;
            res_r           <= 24'h00_0000;
            tdata_r         <= 32'h0000_0000;
            tkeep_r         <= 4'b0000;
            tlast_r         <= 1'b0;
            tvalid_r        <= 1'b0;
        end else begin
            run_r           <= 1'b1;
            flush_pending_r <= flush_nx_s;
            r_r             <= r_nx_s;
            res_r           <= res_nx_s;
            if (emit_s) begin
                tdata_r  <= word_s;
                tkeep_r  <= keep_s;
                tlast_r  <= last_s;
                tvalid_r <= 1'b1;
            end else if (m_axis_tready) begin
                tvalid_r <= 1'b0;
            end else begin
                tvalid_r <= tvalid_r;
            end
        end
    end

endmodule

// File: tb/tb_str_pack_24to32.sv
// Directed bench for str_pack_24to32: vector table, backpressure, long frame and
// mid-frame reset sequences, checked against hand values and a byte-queue model.
module tb_str_pack_24to32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;

    always #5 clk = ~clk;

    str_pack_24to32 #(.DW(24), .OW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  k;
        logic        t;
    } wrd_t;

    typedef struct {
        logic [23:0] d;
        logic        l;
        int          stall;
        int          n;
        logic [31:0] w0;
        logic [3:0]  k0;
        logic        t0;
        logic [31:0] w1;
        logic [3:0]  k1;
        logic        t1;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    wrd_t obs_q[$];
    wrd_t exp_q[$];
    logic [7:0] mb[$];
    vec_t tbl[14];

    // Every handshaken output word, captured mid-cycle before its transfer edge.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid && m_axis_tready)
            obs_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain byte queue, four bytes per word, zero-padded tail on tlast.
    task automatic model_push(input logic [23:0] d, input logic l);
        logic [31:0] w;
        int          n;
        mb.push_back(d[7:0]);
        mb.push_back(d[15:8]);
        mb.push_back(d[23:16]);
        while (mb.size() >= 4) begin
            w = {mb[3], mb[2], mb[1], mb[0]};
            repeat (4) void'(mb.pop_front());
            exp_q.push_back({w, 4'hF, (l && mb.size() == 0)});
        end
        if (l && mb.size() > 0) begin
            n = mb.size();
            w = 32'h0;
            for (int i = 0; i < n; i++) w[i*8 +: 8] = mb[i];
            exp_q.push_back({w, (4'hF >> (4 - n)), 1'b1});
            mb.delete();
        end
    endtask

    task automatic send(input logic [23:0] d, input logic l, output int stalls);
        bit acc;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        stalls = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = s_axis_tready;
            @(posedge clk);
            #1;
            if (!acc) begin
                stalls++;
                if (stalls > 200) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout: got no accept after %0d cycles expected accept", stalls);
                    break;
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic check_q(input string name);
        chk({name, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s_word%0d", name, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_m_tvalid"}, m_axis_tvalid, 1'b0);
        chk({name, "_m_tdata"},  m_axis_tdata, 32'h0);
        chk({name, "_m_tkeep"},  m_axis_tkeep, 4'h0);
        chk({name, "_m_tlast"},  m_axis_tlast, 1'b0);
        chk({name, "_s_tready"}, s_axis_tready, 1'b0);
    endtask

    initial begin
        int st;
        logic [31:0] hold;
        logic [23:0] d;

        tbl[0]  = '{24'h111111, 1'b0, 0, 0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[1]  = '{24'h222222, 1'b0, 0, 1, 32'h22111111, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[2]  = '{24'h333333, 1'b0, 0, 1, 32'h33332222, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[3]  = '{24'h444444, 1'b0, 0, 1, 32'h44444433, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[4]  = '{24'hABCDEF, 1'b1, 0, 1, 32'h00ABCDEF, 4'h7, 1'b1, 32'h0,        4'h0, 1'b0};
        tbl[5]  = '{24'h111111, 1'b0, 0, 0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[6]  = '{24'h222222, 1'b1, 0, 2, 32'h22111111, 4'hF, 1'b0, 32'h00002222, 4'h3, 1'b1};
        tbl[7]  = '{24'hA1A2A3, 1'b0, 1, 0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[8]  = '{24'hB1B2B3, 1'b0, 0, 1, 32'hB3A1A2A3, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[9]  = '{24'hC1C2C3, 1'b1, 0, 2, 32'hC2C3B1B2, 4'hF, 1'b0, 32'h000000C1, 4'h1, 1'b1};
        tbl[10] = '{24'h010203, 1'b0, 1, 0, 32'h0,        4'h0, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[11] = '{24'h040506, 1'b0, 0, 1, 32'h06010203, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[12] = '{24'h070809, 1'b0, 0, 1, 32'h08090405, 4'hF, 1'b0, 32'h0,        4'h0, 1'b0};
        tbl[13] = '{24'h0A0B0C, 1'b1, 0, 1, 32'h0A0B0C07, 4'hF, 1'b1, 32'h0,        4'h0, 1'b0};

        rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 24'h0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;

        // Reset state and the first-edge rise of s_axis_tready.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("tready_before_edge", s_axis_tready, 1'b0);
        @(negedge clk);
        chk("tready_after_edge", s_axis_tready, 1'b1);
        @(posedge clk);
        #1;

        // Vector table: stalls before acceptance and the words each sample produces.
        for (int i = 0; i < 14; i++) begin
            send(tbl[i].d, tbl[i].l, st);
            chk($sformatf("stall%0d", i), st, tbl[i].stall);
            if (tbl[i].n > 0) exp_q.push_back({tbl[i].w0, tbl[i].k0, tbl[i].t0});
            if (tbl[i].n > 1) exp_q.push_back({tbl[i].w1, tbl[i].k1, tbl[i].t1});
        end
        drain();
        check_q("table");

        // Downstream stall of 5 cycles in the middle of a frame.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    d = 24'h010203 + 24'h030507 * i[23:0];
                    model_push(d, (i == 7));
                    send(d, (i == 7), st);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                m_axis_tready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("bp_tvalid%0d", i), m_axis_tvalid, 1'b1);
                    chk($sformatf("bp_s_tready%0d", i), s_axis_tready, 1'b0);
                    if (i == 0) hold = m_axis_tdata;
                    else chk($sformatf("bp_tdata%0d", i), m_axis_tdata, hold);
                end
                @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        drain();
        check_q("backpressure");

        // 16000-sample frame followed directly by a single-sample frame.
        for (int i = 0; i < 16000; i++) begin
            d = (i * 7919 + 13) & 24'hFFFFFF;
            model_push(d, (i == 15999));
            send(d, (i == 15999), st);
        end
        drain();
        chk("long_word_count", obs_q.size(), 12000);
        if (obs_q.size() > 0) begin
            chk("long_last_keep", obs_q[obs_q.size()-1].k, 4'hF);
            chk("long_last_tlast", obs_q[obs_q.size()-1].t, 1'b1);
        end
        check_q("long");
        send(24'h5A5A5A, 1'b1, st);
        exp_q.push_back({32'h005A5A5A, 4'h7, 1'b1});
        drain();
        check_q("after_long");

        // Reset in mid-frame while an output word is held.
        m_axis_tready = 1'b0;
        send(24'h123456, 1'b0, st);
        send(24'h789ABC, 1'b0, st);
        chk("held_word_valid", m_axis_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        check_idle_outputs("midreset_edge");
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        send(24'hABCDEF, 1'b1, st);
        exp_q.push_back({32'h00ABCDEF, 4'h7, 1'b1});
        drain();
        check_q("post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/str_pack_24to32.md
STR_PACK_24TO32 -- requirements
Module: str_pack_24to32

Interface
REQ-001 SHALL have parameter DW, default 24: input sample width; only value 24 is legal, and elaboration SHALL fail for other values.
REQ-002 SHALL have parameter OW, default 32: output word width; fixed, with 4 byte lanes.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port s_axis_tdata, input, DW bits: signed sample from the down-sampling stage; packed as raw bits.
REQ-006 SHALL have port s_axis_tvalid, input, 1 bit: upstream sample valid.
REQ-007 SHALL have port s_axis_tlast, input, 1 bit: last sample of frame.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: this block accepts a sample.
REQ-009 SHALL have port m_axis_tdata, output, OW bits: packed little-endian byte stream.
REQ-010 SHALL have port m_axis_tkeep, output, 4 bits: valid byte lanes of the current word.
REQ-011 SHALL have port m_axis_tlast, output, 1 bit: final word of frame.
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit: output word valid.
REQ-013 SHALL have port m_axis_tready, input, 1 bit: downstream (DMA) accepts the word.

Function
REQ-014 SHALL treat the input stream as a byte stream: sample n occupies stream bytes 3n..3n+2, least significant byte first.
REQ-015 SHALL form output word k from stream bytes 4k..4k+3, with byte 4k in tdata[7:0].
REQ-016 SHALL accept a sample only on a cycle where s_axis_tvalid and s_axis_tready are both 1.
REQ-017 SHALL track a residual byte count r in {0,1,2,3}; each accepted sample adds 3 bytes.
REQ-018 SHALL emit one full word (tkeep=4'hF) whenever accumulated bytes reach 4, leaving r+3-4 residual bytes; phase sequence is 0→3→2→1→0.
REQ-019 SHALL register the output word with a latency of 1 cycle from the accepting clock edge to m_axis_tvalid=1.
REQ-020 SHALL hold m_axis_tvalid and tdata/tkeep/tlast stable while tvalid=1 and tready=0; tvalid SHALL NOT drop without a handshake.
REQ-021 SHALL drive s_axis_tready = !flush_pending && (!m_axis_tvalid || m_axis_tready), giving 1 sample/cycle sustained with no bubbles outside flush.
REQ-022 SHALL process an accepted sample with tlast=1 per r before the sample:
- r=1: one full word, tkeep=F, tlast=1.
- r=0: one word with bytes 0-2 valid, byte 3 zero, tkeep=4'b0111, tlast=1.
- r=3: full word (tlast=0), then a flush word with 2 bytes, tkeep=4'b0011, tlast=1.
- r=2: full word (tlast=0), then a flush word with 1 byte, tkeep=4'b0001, tlast=1.
REQ-023 SHALL, during flush_pending, hold s_axis_tready=0.
REQ-024 SHALL, during flush_pending, emit the flush word on the first cycle the output register frees, then clear flush_pending.
REQ-025 SHALL set r=0 after the tlast word.
REQ-026 SHALL drive unused byte lanes to 0.
REQ-027 SHALL assert tlast only on the final word of a frame.
REQ-028 SHALL keep frames word-aligned: a new frame always starts at output byte lane 0.
REQ-029 SHALL allow back-to-back frames: a first sample of the next frame presented in the cycle after the tlast word is accepted SHALL be packed without loss.

Reset
REQ-030 SHALL, while rst_n=0, drive m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0 and s_axis_tready=0.
REQ-031 SHALL, while rst_n=0, clear r, flush_pending and the residual byte holding register.
REQ-032 SHALL discard any partial word, pending flush and pending output word when reset asserts mid-frame; output resumes at a frame boundary.
REQ-033 SHALL raise s_axis_tready to 1 on the first clock edge after rst_n deasserts.

Verification
REQ-034 Samples 0x111111, 0x222222, 0x333333, 0x444444, no tlast, m_tready=1 -> words 0x22111111, 0x33332222, 0x44444433, all tkeep=F, tlast=0, no stall.
REQ-035 Single-sample frame 0xABCDEF with tlast, r=0 -> one word 0x00ABCDEF, tkeep=4'b0111, tlast=1.
REQ-036 Frame 0x111111, 0x222222 (tlast on 2nd) -> 0x22111111 (tkeep=F, tlast=0), then 0x00002222 (tkeep=4'b0011, tlast=1); s_axis_tready=0 for exactly 1 cycle when m_tready=1.
REQ-037 Continuous stream with m_axis_tready held 0 for 5 cycles mid-frame -> tvalid stays 1, tdata unchanged, s_axis_tready=0; no word lost or duplicated after release.
REQ-038 Frame of 16000 samples -> exactly 12000 words; last word tkeep=F, tlast=1; next frame's first word carries sample 0 in bytes 0-2.
REQ-039 rst_n pulsed low after 2 samples of a frame, then frame 0xABCDEF with tlast -> outputs 0 during reset, only 0x00ABCDEF/0111/tlast=1 afterwards.
